// File: rtl/sim_run_pkg.sv
// Shared types and constants for the simulation run controller.
// Imported by the controller top and its char FIFO.
package sim_run_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        RUN,
        DRAIN,
        DONE,
        TOUT
    } run_state_e;

    localparam logic [17:0] DEF_UART_ADDR = 18'h30000;
    localparam logic [17:0] DEF_HALT_ADDR = 18'h30004;
    localparam logic [7:0]  TIMEOUT_CODE  = 8'hFF;

    // Cycle counting spans the live program plus the drain tail.
    function automatic logic is_counting(run_state_e s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// CPU IO write bus plus the buffered character stream seen by the bench.
// The controller takes the slave side; the CPU/consumer side is the master.
interface sim_run_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              io_wr_en;
    logic [ADDR_W-1:0] io_addr;
    logic [7:0]        io_wdata;
    logic              io_stall;
    logic              char_valid;
    logic [7:0]        char_data;
    logic              char_ready;

    modport master (
        output io_wr_en, io_addr, io_wdata, char_ready,
        input  io_stall, char_valid, char_data
    );

    modport slave (
        input  io_wr_en, io_addr, io_wdata, char_ready,
        output io_stall, char_valid, char_data
    );
endinterface

// File: rtl/sim_char_fifo.sv
// Small synchronous FIFO buffering UART bytes; no push-to-pop bypass,
// pushes are dropped while full and pops are ignored while empty.
module sim_char_fifo
    import sim_run_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign valid   = (count != '0);
    assign data    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Bench-side run controller: staggered reset release, IO-bus snooping, watchdog.
// Define SIM_RUN_TRACE_EN to echo characters and end the simulation from here.
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int                RST_CYCLES     = 25,
    parameter int                NUM_DOMAINS    = 2,
    parameter int                STAGGER        = 4,
    parameter int                ADDR_W         = 18,
    parameter logic [ADDR_W-1:0] UART_ADDR      = DEF_UART_ADDR,
    parameter logic [ADDR_W-1:0] HALT_ADDR      = DEF_HALT_ADDR,
    parameter int                FIFO_DEPTH     = 16,
    parameter int                CNT_W          = 32,
    parameter int                TIMEOUT_CYCLES = 150_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    sim_run_ctrl_if.slave          bus,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic                   run_done,
    output logic                   timeout,
    output logic [7:0]             exit_code
);

    localparam int              SEQ_W    = 32;
    localparam logic [SEQ_W-1:0] LAST_REL = SEQ_W'((NUM_DOMAINS - 1) * STAGGER);

    run_state_e             state;
    run_state_e             state_next;
    logic [SEQ_W-1:0]       seq_cnt;
    logic                   hold_done;
    logic [NUM_DOMAINS-1:0] drop_mask;
    logic                   uart_wr;
    logic                   halt_wr;
    logic                   tout_hit;

    assign uart_wr  = (state == RUN) && bus.io_wr_en && (bus.io_addr == UART_ADDR);
    assign halt_wr  = (state == RUN) && bus.io_wr_en && (bus.io_addr == HALT_ADDR);
    assign tout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    sim_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (uart_wr),
        .push_data (bus.io_wdata),
        .full      (bus.io_stall),
        .pop       (bus.char_ready),
        .valid     (bus.char_valid),
        .data      (bus.char_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Halt is checked before the watchdog so a last-moment halt still counts.
    always_comb begin
        state_next = state;
        hold_done  = (state == HOLD) && (seq_cnt == SEQ_W'(RST_CYCLES - 1));
        case (state)
            HOLD: begin
                if (hold_done) begin
                    state_next = (LAST_REL == '0) ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                if (seq_cnt == LAST_REL) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_wr) begin
                    state_next = DRAIN;
                end else if (tout_hit) begin
                    state_next = TOUT;
                end
            end
            DRAIN: begin
                if (!bus.char_valid) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // The HOLD exit edge is release cycle 0, so domain 0 drops on entry.
    always_comb begin
        drop_mask = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (hold_done && (i * STAGGER == 0)) begin
                drop_mask[i] = 1'b1;
            end
            if ((state == RELEASE) && (seq_cnt == SEQ_W'(i * STAGGER))) begin
                drop_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_cnt <= '0;
        end else if (hold_done) begin
            seq_cnt <= SEQ_W'(1);
        end else if ((state == HOLD) || (state == RELEASE)) begin
            seq_cnt <= seq_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_out <= '1;
        end else if ((state_next == DONE) || (state_next == TOUT)) begin
            rst_out <= '1;
        end else begin
            rst_out <= rst_out & ~drop_mask;
        end
    end

    // The edge leaving RUN/DRAIN for a terminal state is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (is_counting(state) && is_counting(state_next) && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_done  <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
        end else begin
            if ((state == DRAIN) && (state_next == DONE)) begin
                run_done <= 1'b1;
            end
            if (halt_wr) begin
                exit_code <= bus.io_wdata;
            end else if ((state == RUN) && (state_next == TOUT)) begin
                timeout   <= 1'b1;
                exit_code <= TIMEOUT_CODE;
            end
        end
    end

`ifdef SIM_RUN_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.char_valid && bus.char_ready) begin
                $write("%c", bus.char_data);
            end
            if ((state != DONE) && (state_next == DONE)) begin
                $display("run done: exit_code=%0d cycles=%0d", exit_code, cycle_cnt);
                $finish;
            end
            if ((state != TOUT) && (state_next == TOUT)) begin
                $display("TIMEOUT");
                $finish;
            end
        end
    end
`else
    // Synthesizable build: the bench polls run_done and timeout instead.
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: reset sequencing, char FIFO, halt, watchdog.
// Watchdog shortened to 100 cycles so the timeout path is reachable.
module tb_sim_run_ctrl;

    localparam logic [17:0] UART = 18'h30000;
    localparam logic [17:0] HALT = 18'h30004;
    localparam logic [17:0] OTHR = 18'h30008;

    logic        clk;
    logic        rst;
    logic [1:0]  rst_out;
    logic [31:0] cycle_cnt;
    logic        run_done;
    logic        timeout;
    logic [7:0]  exit_code;

    int totalChecks = 0;
    int badChecks   = 0;

    sim_run_ctrl_if #(.ADDR_W(18)) bus ();

    sim_run_ctrl #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rst_out   (rst_out),
        .cycle_cnt (cycle_cnt),
        .run_done  (run_done),
        .timeout   (timeout),
        .exit_code (exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [17:0] addr,
                                 input logic [7:0] data, input logic ready);
        bus.io_wr_en   = wr;
        bus.io_addr    = addr;
        bus.io_wdata   = data;
        bus.char_ready = ready;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the DUT one edge into RUN with cycle_cnt at zero.
    task automatic doReset();
        applyStimulus(1'b0, 18'h0, 8'h00, 1'b0);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(29);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 18'h0, 8'h00, 1'b0);

        tick(3);
        checkOutput("rst_rst_out", 32'(rst_out), 32'h3);
        checkOutput("rst_valid", 32'(bus.char_valid), 32'h0);
        checkOutput("rst_stall", 32'(bus.io_stall), 32'h0);
        checkOutput("rst_cycle", cycle_cnt, 32'h0);
        checkOutput("rst_done", 32'(run_done), 32'h0);
        checkOutput("rst_tout", 32'(timeout), 32'h0);
        checkOutput("rst_exit", 32'(exit_code), 32'h0);
        rst = 1'b0;
        tick(24);
        checkOutput("seq_e24", 32'(rst_out), 32'h3);
        tick(1);
        checkOutput("seq_e25", 32'(rst_out), 32'h2);
        tick(3);
        checkOutput("seq_e28", 32'(rst_out), 32'h2);
        tick(1);
        checkOutput("seq_e29", 32'(rst_out), 32'h0);
        checkOutput("seq_cnt0", cycle_cnt, 32'h0);
        tick(1);
        checkOutput("seq_cnt1", cycle_cnt, 32'h1);

        doReset();
        applyStimulus(1'b1, OTHR, 8'h55, 1'b1);
        tick(1);
        checkOutput("t2_other_addr", 32'(bus.char_valid), 32'h0);
        applyStimulus(1'b1, UART, 8'h48, 1'b1);
        tick(1);
        checkOutput("t2_v_H", 32'(bus.char_valid), 32'h1);
        checkOutput("t2_d_H", 32'(bus.char_data), 32'h48);
        applyStimulus(1'b1, UART, 8'h69, 1'b1);
        tick(1);
        checkOutput("t2_v_i", 32'(bus.char_valid), 32'h1);
        checkOutput("t2_d_i", 32'(bus.char_data), 32'h69);
        applyStimulus(1'b1, UART, 8'h0A, 1'b1);
        tick(1);
        checkOutput("t2_d_nl", 32'(bus.char_data), 32'h0A);
        applyStimulus(1'b0, UART, 8'h00, 1'b1);
        tick(1);
        checkOutput("t2_empty", 32'(bus.char_valid), 32'h0);

        doReset();
        for (int n = 1; n <= 16; n++) begin
            checkOutput("t3_nostall", 32'(bus.io_stall), 32'h0);
            applyStimulus(1'b1, UART, 8'(n), 1'b0);
            tick(1);
        end
        checkOutput("t3_full", 32'(bus.io_stall), 32'h1);
        checkOutput("t3_head", 32'(bus.char_data), 32'h1);
        applyStimulus(1'b1, UART, 8'd17, 1'b0);
        tick(1);
        checkOutput("t3_held", 32'(bus.io_stall), 32'h1);
        checkOutput("t3_head2", 32'(bus.char_data), 32'h1);
        applyStimulus(1'b1, UART, 8'd17, 1'b1);
        tick(1);
        checkOutput("t3_after_pop", 32'(bus.io_stall), 32'h0);
        applyStimulus(1'b1, UART, 8'd17, 1'b0);
        tick(1);
        checkOutput("t3_refull", 32'(bus.io_stall), 32'h1);
        applyStimulus(1'b0, UART, 8'h00, 1'b1);
        for (int k = 2; k <= 17; k++) begin
            checkOutput("t3_order", 32'(bus.char_data), 32'(k));
            tick(1);
        end
        checkOutput("t3_drained", 32'(bus.char_valid), 32'h0);

        doReset();
        applyStimulus(1'b1, UART, 8'h61, 1'b0);
        tick(1);
        applyStimulus(1'b1, UART, 8'h62, 1'b0);
        tick(1);
        applyStimulus(1'b1, UART, 8'h63, 1'b0);
        tick(1);
        applyStimulus(1'b1, HALT, 8'h2A, 1'b0);
        tick(1);
        checkOutput("t4_exit", 32'(exit_code), 32'h2A);
        checkOutput("t4_notdone", 32'(run_done), 32'h0);
        applyStimulus(1'b0, UART, 8'h00, 1'b1);
        tick(3);
        checkOutput("t4_lastpop", 32'(run_done), 32'h0);
        checkOutput("t4_empty", 32'(bus.char_valid), 32'h0);
        tick(1);
        checkOutput("t4_done", 32'(run_done), 32'h1);
        checkOutput("t4_rst_out", 32'(rst_out), 32'h3);
        checkOutput("t4_exit2", 32'(exit_code), 32'h2A);
        checkOutput("t4_cycles", cycle_cnt, 32'd7);
        applyStimulus(1'b1, UART, 8'h7A, 1'b1);
        tick(1);
        checkOutput("t4_nopush", 32'(bus.char_valid), 32'h0);
        checkOutput("t4_frozen", cycle_cnt, 32'd7);

        doReset();
        applyStimulus(1'b1, UART, 8'h21, 1'b0);
        tick(1);
        applyStimulus(1'b0, UART, 8'h00, 1'b0);
        tick(98);
        checkOutput("t5_cnt99", cycle_cnt, 32'd99);
        checkOutput("t5_pre", 32'(timeout), 32'h0);
        tick(1);
        checkOutput("t5_tout", 32'(timeout), 32'h1);
        checkOutput("t5_exit", 32'(exit_code), 32'hFF);
        checkOutput("t5_frozen", cycle_cnt, 32'd99);
        checkOutput("t5_rst_out", 32'(rst_out), 32'h3);
        checkOutput("t5_queued", 32'(bus.char_valid), 32'h1);
        applyStimulus(1'b0, UART, 8'h00, 1'b1);
        tick(1);
        checkOutput("t5_drains", 32'(bus.char_valid), 32'h0);
        checkOutput("t5_frozen2", cycle_cnt, 32'd99);
        checkOutput("t5_sticky", 32'(timeout), 32'h1);

        doReset();
        tick(99);
        applyStimulus(1'b1, HALT, 8'h55, 1'b0);
        tick(1);
        checkOutput("t5h_tout", 32'(timeout), 32'h0);
        checkOutput("t5h_exit", 32'(exit_code), 32'h55);
        applyStimulus(1'b0, UART, 8'h00, 1'b0);
        tick(1);
        checkOutput("t5h_done", 32'(run_done), 32'h1);
        checkOutput("t5h_tout2", 32'(timeout), 32'h0);

        doReset();
        applyStimulus(1'b1, UART, 8'h31, 1'b0);
        tick(1);
        applyStimulus(1'b1, UART, 8'h32, 1'b0);
        tick(1);
        checkOutput("t6_queued", 32'(bus.char_valid), 32'h1);
        applyStimulus(1'b0, UART, 8'h00, 1'b0);
        rst = 1'b1;
        tick(1);
        checkOutput("t6_valid", 32'(bus.char_valid), 32'h0);
        checkOutput("t6_cycle", cycle_cnt, 32'h0);
        checkOutput("t6_rst_out", 32'(rst_out), 32'h3);
        checkOutput("t6_exit", 32'(exit_code), 32'h0);
        rst = 1'b0;
        tick(24);
        checkOutput("t6_e24", 32'(rst_out), 32'h3);
        tick(1);
        checkOutput("t6_e25", 32'(rst_out), 32'h2);
        tick(4);
        checkOutput("t6_e29", 32'(rst_out), 32'h0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
